// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/funct, registers operands, runs alu_32, returns flags.
// Optional: OVERFLOW_TRAP_EN zeroes the result and flags resp_ill on signed add/sub overflow.

module alu_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_ctrl,
   output logic [31:0] res,
   output logic        zero,
   output logic        carry_out,
   output logic        overflow
);
   logic        sub;
   logic [31:0] b_eff;
   logic [32:0] sum;

   always_comb begin
      res       = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      sub       = (alu_ctrl == 4'b0110);
      b_eff     = sub ? ~b : b;
      sum       = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
      case (alu_ctrl)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010,
         4'b0110: begin
            res       = sum[31:0];
            carry_out = sum[32];
            // Signed overflow: operands agree in sign, result does not.
            overflow  = (a[31] == b_eff[31]) && (sum[31] != a[31]);
         end
         4'b0111: res = {31'd0, ($signed(a) < $signed(b))};
         4'b1100: res = ~(a | b);
         default: res = '0;
      endcase
      zero = (res == 32'd0);
   end
endmodule

module alu_issue_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_res,
   output logic             resp_zero,
   output logic             resp_cout,
   output logic             resp_ovf,
   output logic             resp_ill,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_q, b_q;
   logic [3:0]  ctrl_q, ctrl_dec;
   logic        ill_q, ill_dec;
   logic        trap_q, trap_dec;
   logic [31:0] alu_res;
   logic        alu_zero, alu_cout, alu_ovf;
   logic        accept, resp_hs;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign resp_hs    = resp_valid && resp_ready;

   always_comb begin
      ctrl_dec = 4'b0000;
      ill_dec  = 1'b0;
      trap_dec = 1'b0;
      case (alu_op)
         2'b00: begin ctrl_dec = 4'b0010; trap_dec = 1'b1; end
         2'b01: begin ctrl_dec = 4'b0110; trap_dec = 1'b1; end
         2'b11: ctrl_dec = 4'b0111;
         default: begin
            case (funct)
               6'b100000: begin ctrl_dec = 4'b0010; trap_dec = 1'b1; end
               6'b100001: ctrl_dec = 4'b0010;
               6'b100010: begin ctrl_dec = 4'b0110; trap_dec = 1'b1; end
               6'b100011: ctrl_dec = 4'b0110;
               6'b100100: ctrl_dec = 4'b0000;
               6'b100101: ctrl_dec = 4'b0001;
               6'b101010: ctrl_dec = 4'b0111;
               6'b100111: ctrl_dec = 4'b1100;
               default:   begin ctrl_dec = 4'b0000; ill_dec = 1'b1; end
            endcase
         end
      endcase
   end

   alu_32 u_alu (
      .a         (a_q),
      .b         (b_q),
      .alu_ctrl  (ctrl_q),
      .res       (alu_res),
      .zero      (alu_zero),
      .carry_out (alu_cout),
      .overflow  (alu_ovf)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         ill_q    <= 1'b0;
         trap_q   <= 1'b0;
         resp_res <= '0;
         resp_zero <= 1'b0;
         resp_cout <= 1'b0;
         resp_ovf <= 1'b0;
         resp_ill <= 1'b0;
         op_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q    <= op_a;
            b_q    <= op_b;
            ctrl_q <= ctrl_dec;
            ill_q  <= ill_dec;
            trap_q <= trap_dec;
         end
         if (state == EXEC) begin
            resp_cout <= alu_cout;
            resp_ovf  <= alu_ovf;
`ifdef OVERFLOW_TRAP_EN
            if (trap_q && alu_ovf) begin
               resp_res  <= '0;
               resp_zero <= 1'b0;
               resp_ill  <= 1'b1;
            end else begin
               resp_res  <= alu_res;
               resp_zero <= alu_zero;
               resp_ill  <= ill_q;
            end
`else
            resp_res  <= alu_res;
            resp_zero <= alu_zero;
            resp_ill  <= ill_q;
`endif
         end
         if (resp_hs) op_count <= op_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; small counter width so the wrap is reachable.

module tb_alu_issue_ctrl;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    alu_op = 2'b00;
   logic [5:0]    funct = 6'b000000;
   logic [31:0]   op_a = '0;
   logic [31:0]   op_b = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b1;
   logic [31:0]   resp_res;
   logic          resp_zero, resp_cout, resp_ovf, resp_ill;
   logic [CW-1:0] op_count;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [CW-1:0] exp_count = '0;

   alu_issue_ctrl #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .alu_op     (alu_op),
      .funct      (funct),
      .op_a       (op_a),
      .op_b       (op_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_res   (resp_res),
      .resp_zero  (resp_zero),
      .resp_cout  (resp_cout),
      .resp_ovf   (resp_ovf),
      .resp_ill   (resp_ill),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
   endtask

   // Full transaction with resp_ready=1: accept, EXEC, RESP sample, handshake.
   task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic ez, input logic ec,
                        input logic eo, input logic ei);
      @(negedge clk);
      wait_ready();
      req_valid = 1'b1; alu_op = op; funct = fn; op_a = a; op_b = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "_exec_valid"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      check({tag, "_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_res"},   resp_res, eres);
      check({tag, "_zero"},  32'(resp_zero), 32'(ez));
      check({tag, "_cout"},  32'(resp_cout), 32'(ec));
      check({tag, "_ovf"},   32'(resp_ovf), 32'(eo));
      check({tag, "_ill"},   32'(resp_ill), 32'(ei));
      @(posedge clk); #1;
      exp_count = exp_count + 1'b1;
      check({tag, "_hs_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_count"},    32'(op_count), 32'(exp_count));
   endtask

   logic [31:0] ra, rb, held;

   initial begin
      // Reset state
      #12;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      check("rst_res",   resp_res, 32'd0);
      check("rst_flags", {28'd0, resp_zero, resp_cout, resp_ovf, resp_ill}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Reset asserted during EXEC drops the request
      @(negedge clk);
      req_valid = 1'b1; alu_op = 2'b00; op_a = 32'd5; op_b = 32'd6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("exec_busy", 32'(req_ready), 32'd0);
      rst_n = 1'b0; #1;
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_valid", 32'(resp_valid), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("midrst_noresp", 32'(resp_valid), 32'd0);
      end
      check("midrst_count", 32'(op_count), 32'd0);

      issue("add",      2'b10, 6'b100000, 32'd256, 32'd256, 32'd512, 0, 0, 0, 0);
      issue("beq_sub",  2'b01, 6'b000000, -32'sd50, -32'sd50, 32'd0, 1, 1, 0, 0);
      issue("slti_0",   2'b11, 6'b000000, 32'd12, 32'd10, 32'd0, 1, 0, 0, 0);
      issue("slti_1",   2'b11, 6'b000000, -32'sd14, -32'sd12, 32'd1, 0, 0, 0, 0);
      issue("sub_neg",  2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0);
      issue("slt_r",    2'b10, 6'b101010, -32'sd1, 32'd0, 32'd1, 0, 0, 0, 0);
      issue("and",      2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0);
      issue("illegal",  2'b10, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 1);
      issue("addu_ovf", 2'b10, 6'b100001, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 1, 0);
      issue("subu_ovf", 2'b10, 6'b100011, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 1, 0);
`ifdef OVERFLOW_TRAP_EN
      issue("add_ovf",  2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'd0, 0, 0, 1, 1);
      issue("lw_ovf",   2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1, 32'd0, 0, 0, 1, 1);
      issue("beq_ovf",  2'b01, 6'b000000, 32'h8000_0000, 32'd1, 32'd0, 0, 1, 1, 1);
`else
      issue("add_ovf",  2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 1, 0);
      issue("lw_ovf",   2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 1, 0);
      issue("beq_ovf",  2'b01, 6'b000000, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 1, 0);
`endif

      // Backpressure: first response held while a second request waits
      resp_ready = 1'b0;
      @(negedge clk);
      wait_ready();
      req_valid = 1'b1; alu_op = 2'b10; funct = 6'b100101;
      op_a = 32'h0000_00F0; op_b = 32'h0000_0F00;
      @(posedge clk); #1;
      alu_op = 2'b10; funct = 6'b100000; op_a = 32'd100; op_b = 32'd23;
      @(posedge clk); #1;
      check("bp_valid", 32'(resp_valid), 32'd1);
      held = resp_res;
      check("bp_res", held, 32'h0000_0FF0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_ready_low", 32'(req_ready), 32'd0);
         check("bp_hold_valid", 32'(resp_valid), 32'd1);
         check("bp_hold_res", resp_res, 32'h0000_0FF0);
      end
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1;
      exp_count = exp_count + 1'b1;
      check("bp_release_valid", 32'(resp_valid), 32'd0);
      check("bp_release_ready", 32'(req_ready), 32'd1);
      check("bp_release_count", 32'(op_count), 32'(exp_count));
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_second_accept", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_second_valid", 32'(resp_valid), 32'd1);
      check("bp_second_res", resp_res, 32'd123);
      @(posedge clk); #1;
      exp_count = exp_count + 1'b1;
      check("bp_second_count", 32'(op_count), 32'(exp_count));

      // Random or/nor ops; running past 2**CW handshakes exercises the counter wrap
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 2 == 0)
            issue("or_rand", 2'b10, 6'b100101, ra, rb, ra | rb, (ra | rb) == 0, 0, 0, 0);
         else
            issue("nor_rand", 2'b10, 6'b100111, ra, rb, ~(ra | rb), (~(ra | rb)) == 0, 0, 0, 0);
         if (exp_count == '0) check("count_wrap", 32'(op_count), 32'd0);
      end
      issue("nor_zero", 2'b10, 6'b100111, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
